// File: rtl/log_base_eight.sv
// log_base_eight
// ---------------------------------------------------------------------------
// Iterative decoder for the power-of-eight stream. It takes a WIDTH-bit value
// that should equal 8^n and returns n. Inputs that are zero or are not an
// exact power of eight are flagged as errors. The engine handles one value at
// a time and examines 3 bits per clock.
//
// Ports
//   i_clock        rising-edge clock
//   i_reset_async  asynchronous, active-high reset
//   i_status       input valid (sampled only while o_ready=1)
//   i_value        candidate power of eight
//   o_ready        engine idle and able to accept
//   o_status       one-cycle result-valid pulse
//   o_value        decoded exponent n; all ones on error
//   o_error        input was 0 or not an exact power of eight (qualified by
//                  o_status, held until the next result)
//   o_debug_state  current FSM state (0 = IDLE, 1 = SCAN)
//
// Handshake: a transfer occurs on a rising edge where o_ready=1 and
// i_status=1. While o_ready=0, i_status and i_value are ignored: data offered
// then is dropped, not queued, so the producer must hold it until o_ready
// returns. There is no back-pressure on the result side. o_status is a single
// cycle pulse, and o_value/o_error keep their last result between pulses.
// ---------------------------------------------------------------------------
module log_base_eight #(
  parameter int WIDTH     = 61,
  parameter int EXP_WIDTH = 5
) (
  input  logic                 i_clock,
  input  logic                 i_reset_async,
  input  logic                 i_status,
  input  logic [WIDTH-1:0]     i_value,
  output logic                 o_ready,
  output logic                 o_status,
  output logic [EXP_WIDTH-1:0] o_value,
  output logic                 o_error,
  output logic                 o_debug_state
);

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [EXP_WIDTH-1:0] ERR_CODE = '1;
  localparam logic [WIDTH-1:0]     ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     shift_q, shift_d;
  logic [EXP_WIDTH-1:0] count_q, count_d;
  logic                 ready_d;
  logic                 status_d;
  logic [EXP_WIDTH-1:0] value_d;
  logic                 error_d;

  // The shift register has reduced to exactly 1: the input was 8^count.
  logic scan_hit;
  // Nothing left to scan, or a set bit below the next octal digit boundary:
  // the input cannot be an exact power of eight.
  logic scan_miss;

  assign scan_hit  = (shift_q == ONE);
  assign scan_miss = (shift_q == '0) || (shift_q[2:0] != 3'b000);

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    count_d  = count_q;
    ready_d  = o_ready;
    status_d = 1'b0;
    value_d  = o_value;
    error_d  = o_error;

    case (state_q)
      IDLE: begin
        if (i_status) begin
          shift_d = i_value;
          count_d = '0;
          state_d = SCAN;
          ready_d = 1'b0;
        end
      end

      SCAN: begin
        // Exact match takes priority, so that a lone 1 in bit 0 is reported
        // as a valid exponent rather than as an error.
        if (scan_hit) begin
          value_d  = count_q;
          error_d  = 1'b0;
          status_d = 1'b1;
          state_d  = IDLE;
          ready_d  = 1'b1;
        end else if (scan_miss) begin
          value_d  = ERR_CODE;
          error_d  = 1'b1;
          status_d = 1'b1;
          state_d  = IDLE;
          ready_d  = 1'b1;
        end else begin
          // Low octal digit is zero: drop it and count one more factor of 8.
          // The count cannot exceed 20 for a 61-bit input.
          shift_d = shift_q >> 3;
          count_d = count_q + EXP_WIDTH'(1);
        end
      end

      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers. A reset during SCAN discards the value being
  // decoded without producing a result pulse.
  always_ff @(posedge i_clock or posedge i_reset_async) begin
    if (i_reset_async) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      count_q  <= '0;
      o_ready  <= 1'b1;
      o_status <= 1'b0;
      o_value  <= '0;
      o_error  <= 1'b0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      count_q  <= count_d;
      o_ready  <= ready_d;
      o_status <= status_d;
      o_value  <= value_d;
      o_error  <= error_d;
    end
  end

  assign o_debug_state = (state_q == SCAN);

endmodule
